icache_sa: RTL and testbench

//  Parametrised N-way set-associative instruction cache with multi-word blocks.

---
 rtl/icache_pkg.sv | 31 +++
 rtl/icache_sa_if.sv | 14 +
 rtl/icache_way.sv | 45 ++++
 rtl/icache_sa.sv | 143 ++++++++++++++
 tb/tb_icache_sa.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared types and address helpers for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic {IDLE, FILL} icache_state_t;

  // Fields are carried full-width; callers truncate to the configured widths.
  typedef struct packed {
    logic [31:0] tag;
    logic [31:0] index;
    logic [31:0] word;
  } icache_addr_t;

  function automatic int unsigned tag_width(input int unsigned sets, input int unsigned block_words);
    return 32 - 2 - $clog2(sets) - $clog2(block_words);
  endfunction

  function automatic icache_addr_t split_addr(input logic [31:0] addr, input int unsigned ibits,
                                              input int unsigned wbits);
    icache_addr_t f;
    f.tag   = addr >> (2 + wbits + ibits);
    f.index = (addr >> (2 + wbits)) & ((32'd1 << ibits) - 32'd1);
    f.word  = (addr >> 2) & ((32'd1 << wbits) - 32'd1);
    return f;
  endfunction

  function automatic logic [31:0] build_addr(input icache_addr_t f, input int unsigned ibits,
                                             input int unsigned wbits);
    return ((((f.tag << ibits) | f.index) << wbits) | f.word) << 2;
  endfunction

endpackage

// File: rtl/icache_sa_if.sv
// Fetch-side and memory-side handshake signals of the instruction cache.
interface icache_sa_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave  (input imemREN, imemaddr, iwait, iload, output ihit, imemload, iREN, iaddr);
  modport master (output imemREN, imemaddr, iwait, iload, input ihit, imemload, iREN, iaddr);
endinterface

// File: rtl/icache_way.sv
// One cache way: tag, valid and block data storage with combinational lookup.
module icache_way #(
  parameter int unsigned SETS        = 8,
  parameter int unsigned BLOCK_WORDS = 2,
  parameter int unsigned TAG_W       = 26,
  parameter int unsigned IW          = 3,
  parameter int unsigned WW          = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic [IW-1:0]    rd_idx,
  input  logic [WW-1:0]    rd_word,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             match,
  output logic             valid,
  output logic [31:0]      rdata,
  input  logic [IW-1:0]    wr_idx,
  input  logic [WW-1:0]    wr_word,
  input  logic [31:0]      wr_data,
  input  logic             we_data,
  input  logic             we_tag,
  input  logic [TAG_W-1:0] wr_tag
);

  logic [TAG_W-1:0] tags [SETS];
  logic [31:0]      data [SETS][BLOCK_WORDS];
  logic [SETS-1:0]  vbits;

  always_ff @(posedge CLK) begin
    if (we_data) data[wr_idx][wr_word] <= wr_data;
    if (we_tag)  tags[wr_idx] <= wr_tag;
  end

  // Invalidation outranks a completing fill in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST || clr)  vbits <= '0;
    else if (we_tag) vbits[wr_idx] <= 1'b1;
  end

  assign valid = vbits[rd_idx];
  assign match = vbits[rd_idx] && (tags[rd_idx] == rd_tag);
  assign rdata = data[rd_idx][rd_word];

endmodule

// File: rtl/icache_sa.sv
// N-way set-associative instruction cache: same-cycle hits, block fill FSM, hit/miss counters.
module icache_sa import icache_pkg::*; #(
  parameter int unsigned WAYS        = 2,
  parameter int unsigned SETS        = 8,
  parameter int unsigned BLOCK_WORDS = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  icache_sa_if.slave       bus,
  input  logic             flush,
  input  logic             dbusy,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int unsigned WOFF  = $clog2(BLOCK_WORDS);
  localparam int unsigned IW    = $clog2(SETS);
  localparam int unsigned WW    = (WOFF > 0) ? WOFF : 1;
  localparam int unsigned PW    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned TAG_W = tag_width(SETS, BLOCK_WORDS);
  localparam logic [WW-1:0] LAST_WORD = WW'(BLOCK_WORDS - 1);

  icache_state_t state, state_n;
  icache_addr_t  req_f, fill_f, out_f;
  logic [31:0]      fill_addr;
  logic [IW-1:0]    req_idx, fill_idx;
  logic [WW-1:0]    req_word, wcnt;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic [WAYS-1:0]  match, vld;
  logic [31:0]      rdata [WAYS];
  logic [PW-1:0]    hit_way, vsel, victim;
  logic [PW-1:0]    rr [SETS];
  logic             set_full, victim_full;
  logic             hit, miss, iren, we_data, we_tag;

  assign req_f    = split_addr(bus.imemaddr, IW, WOFF);
  assign req_idx  = IW'(req_f.index);
  assign req_word = WW'(req_f.word);
  assign req_tag  = TAG_W'(req_f.tag);
  assign fill_f   = split_addr(fill_addr, IW, WOFF);
  assign fill_idx = IW'(fill_f.index);
  assign fill_tag = TAG_W'(fill_f.tag);

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(
      .SETS(SETS), .BLOCK_WORDS(BLOCK_WORDS), .TAG_W(TAG_W), .IW(IW), .WW(WW)
    ) u_way (
      .CLK(CLK), .RST(RST), .clr(flush),
      .rd_idx(req_idx), .rd_word(req_word), .rd_tag(req_tag),
      .match(match[w]), .valid(vld[w]), .rdata(rdata[w]),
      .wr_idx(fill_idx), .wr_word(wcnt), .wr_data(bus.iload),
      .we_data(we_data && (victim == PW'(w))),
      .we_tag(we_tag && (victim == PW'(w))),
      .wr_tag(fill_tag)
    );
  end

  // Descending scans leave the lowest qualifying way selected.
  always_comb begin
    hit_way  = '0;
    vsel     = rr[req_idx];
    set_full = 1'b1;
    for (int unsigned i = WAYS; i > 0; i--) begin
      if (match[i-1]) hit_way = PW'(i - 1);
      if (!vld[i-1]) begin
        vsel     = PW'(i - 1);
        set_full = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    hit     = 1'b0;
    miss    = 1'b0;
    iren    = 1'b0;
    we_data = 1'b0;
    we_tag  = 1'b0;
    case (state)
      IDLE: if (bus.imemREN && !flush) begin
        if (|match) hit = 1'b1;
        else begin
          miss    = 1'b1;
          state_n = FILL;
        end
      end
      FILL: begin
        iren    = !dbusy;
        we_data = iren && !bus.iwait;
        if (we_data && (wcnt == LAST_WORD)) begin
          we_tag  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_comb begin
    out_f      = fill_f;
    out_f.word = 32'(wcnt);
  end

  assign bus.ihit     = hit;
  assign bus.imemload = hit ? rdata[hit_way] : '0;
  assign bus.iREN     = iren;
  assign bus.iaddr    = iren ? build_addr(out_f, IW, WOFF) : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      fill_addr   <= '0;
      wcnt        <= '0;
      victim      <= '0;
      victim_full <= 1'b0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      for (int unsigned s = 0; s < SETS; s++) rr[s] <= '0;
    end else begin
      if (hit && (hit_cnt != '1)) hit_cnt <= hit_cnt + 1'b1;
      if (miss) begin
        fill_addr   <= bus.imemaddr;
        wcnt        <= '0;
        victim      <= vsel;
        victim_full <= set_full;
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      end
      if (we_data) wcnt <= wcnt + 1'b1;
      if (flush) begin
        for (int unsigned s = 0; s < SETS; s++) rr[s] <= '0;
      end else if (we_tag && victim_full) begin
        rr[fill_idx] <= (rr[fill_idx] == PW'(WAYS - 1)) ? '0 : rr[fill_idx] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_sa.sv
// Bench for icache_sa: block-level cache model checked every cycle plus directed scenarios.
module tb_icache_sa;

  localparam int unsigned WAYS    = 2;
  localparam int unsigned SETS    = 8;
  localparam int unsigned BW      = 2;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned OFFB    = 2 + $clog2(BW);
  localparam int unsigned IBB     = $clog2(SETS);
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             flush = 1'b0;
  logic             dbusy = 1'b0;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  icache_sa_if bus ();

  icache_sa #(.WAYS(WAYS), .SETS(SETS), .BLOCK_WORDS(BW), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .flush(flush), .dbusy(dbusy),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory: one wait cycle per requested word, then data.
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;
  always @(posedge CLK) begin
    pend  <= bus.iREN && bus.iwait;
    paddr <= bus.iaddr;
  end
  assign bus.iwait = !(bus.iREN && pend && (paddr == bus.iaddr));
  assign bus.iload = memf(bus.iaddr);

  int unsigned n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  logic [31:0] xq [$];
  always @(negedge CLK) if (bus.iREN === 1'b1 && bus.iwait === 1'b0) xq.push_back(bus.iaddr);

  function automatic int unsigned set_of(input logic [31:0] a);
    return (a >> OFFB) % SETS;
  endfunction
  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a >> (OFFB + IBB);
  endfunction

  // Model: which blocks are resident in which way, plus the block being fetched.
  bit          mv [WAYS][SETS];
  logic [31:0] mt [WAYS][SETS];
  int unsigned mrr [SETS];
  bit          known = 0, filling = 0, ffull = 0, mpend = 0;
  logic [31:0] fbase = '0, mpaddr = '0;
  int unsigned fw = 0, fvict = 0, mhits = 0, mmiss = 0;

  initial begin : model
    bit          e_hit, e_iren, xfer, found;
    logic [31:0] e_load, e_iaddr, t;
    int unsigned s, fs;
    forever begin
      @(negedge CLK);
      s = set_of(bus.imemaddr);
      t = tag_of(bus.imemaddr);
      e_hit = 0;
      if (!filling && bus.imemREN && !flush)
        for (int unsigned w = 0; w < WAYS; w++) if (mv[w][s] && mt[w][s] == t) e_hit = 1;
      e_load  = e_hit ? memf({bus.imemaddr[31:2], 2'b00}) : '0;
      e_iren  = filling && !dbusy;
      e_iaddr = e_iren ? fbase + 32'(fw * 4) : '0;
      xfer    = e_iren && mpend && (mpaddr == e_iaddr);
      if (known) begin
        chk("ihit", 32'(bus.ihit), 32'(e_hit));
        chk("imemload", bus.imemload, e_load);
        chk("iREN", 32'(bus.iREN), 32'(e_iren));
        chk("iaddr", bus.iaddr, e_iaddr);
        chk("hit_cnt", 32'(hit_cnt), mhits);
        chk("miss_cnt", 32'(miss_cnt), mmiss);
      end
      @(posedge CLK);
      mpend  = e_iren && !xfer;
      mpaddr = e_iaddr;
      if (RST) begin
        known = 1; filling = 0; mhits = 0; mmiss = 0;
        for (int unsigned i = 0; i < SETS; i++) begin
          mrr[i] = 0;
          for (int unsigned w = 0; w < WAYS; w++) mv[w][i] = 0;
        end
      end else begin
        if (e_hit && mhits < CNT_MAX) mhits++;
        if (flush) begin
          filling = 0;
          for (int unsigned i = 0; i < SETS; i++) begin
            mrr[i] = 0;
            for (int unsigned w = 0; w < WAYS; w++) mv[w][i] = 0;
          end
        end else if (filling) begin
          if (xfer) begin
            if (fw == BW - 1) begin
              fs = set_of(fbase);
              mv[fvict][fs] = 1;
              mt[fvict][fs] = tag_of(fbase);
              if (ffull) mrr[fs] = (mrr[fs] + 1) % WAYS;
              filling = 0;
            end else fw++;
          end
        end else if (bus.imemREN && !e_hit) begin
          filling = 1;
          fbase   = bus.imemaddr & ~32'(BW * 4 - 1);
          fw      = 0;
          found   = 0;
          fvict   = mrr[s];
          for (int unsigned w = 0; w < WAYS; w++)
            if (!found && !mv[w][s]) begin fvict = w; found = 1; end
          ffull = !found;
          if (mmiss < CNT_MAX) mmiss++;
        end
      end
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Request a word and wait (bounded) for the hit; lat counts cycles after the request cycle.
  task automatic fetch(input logic [31:0] a, output int unsigned lat, output logic [31:0] load);
    bus.imemREN  = 1'b1;
    bus.imemaddr = a;
    lat = 0;
    @(negedge CLK);
    while (bus.ihit !== 1'b1 && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    load = bus.imemload;
    @(posedge CLK);
    #1;
    bus.imemREN = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int unsigned lat;
    logic [31:0] ld;
    bus.imemREN  = 1'b0;
    bus.imemaddr = '0;
    step(2);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_ihit", 32'(bus.ihit), 32'd0);
    chk("rst_iREN", 32'(bus.iREN), 32'd0);
    chk("rst_iaddr", bus.iaddr, 32'd0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    step(1);

    // Cold miss on 0x40, then reuse of the second word of the block.
    xq.delete();
    fetch(32'h40, lat, ld);
    chk("t1_latency", lat, 32'd5);
    chk("t1_nwords", 32'(xq.size()), 32'd2);
    chk("t1_word0", xq[0], 32'h40);
    chk("t1_word1", xq[1], 32'h44);
    chk("t1_load", ld, memf(32'h40));
    chk("t1_miss_cnt", 32'(miss_cnt), 32'd1);
    xq.delete();
    fetch(32'h44, lat, ld);
    chk("t2_latency", lat, 32'd0);
    chk("t2_load", ld, memf(32'h44));
    chk("t2_nwords", 32'(xq.size()), 32'd0);
    chk("t2_hit_cnt", 32'(hit_cnt), 32'd2);

    // Set 0 replacement: 0xC0 evicts way0 (0x40); 0x40 then evicts 0x80.
    fetch(32'h80, lat, ld);  chk("t3_80_miss", lat, 32'd5);
    fetch(32'hC0, lat, ld);  chk("t3_C0_miss", lat, 32'd5);
    fetch(32'h80, lat, ld);  chk("t3_80_hit", lat, 32'd0);
    fetch(32'h40, lat, ld);  chk("t3_40_remiss", lat, 32'd5);
    fetch(32'hC0, lat, ld);  chk("t3_C0_hit", lat, 32'd0);
    chk("t3_miss_cnt", 32'(miss_cnt), 32'd4);

    // dbusy held for 3 cycles after word 0 of a fill.
    flush = 1'b1; step(1); flush = 1'b0;
    xq.delete();
    bus.imemREN = 1'b1; bus.imemaddr = 32'h40;
    step(3);
    dbusy = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("t4_busy_iREN", 32'(bus.iREN), 32'd0);
      step(1);
    end
    dbusy = 1'b0;
    @(negedge CLK);
    chk("t4_resume_iREN", 32'(bus.iREN), 32'd1);
    chk("t4_resume_iaddr", bus.iaddr, 32'h44);
    step(1);
    fetch(32'h40, lat, ld);
    chk("t4_latency", lat, 32'd1);
    chk("t4_load0", ld, memf(32'h40));
    fetch(32'h44, lat, ld);
    chk("t4_load1", ld, memf(32'h44));
    chk("t4_nwords", 32'(xq.size()), 32'd2);

    // Flush aborts a fill; retry refills both words.
    flush = 1'b1; step(1); flush = 1'b0;
    bus.imemREN = 1'b1; bus.imemaddr = 32'h40;
    step(3);
    flush = 1'b1; bus.imemREN = 1'b0;
    @(negedge CLK);
    chk("t5_flush_ihit", 32'(bus.ihit), 32'd0);
    step(1);
    flush = 1'b0;
    @(negedge CLK);
    chk("t5_after_iREN", 32'(bus.iREN), 32'd0);
    step(1);
    xq.delete();
    fetch(32'h40, lat, ld);
    chk("t5_refill_latency", lat, 32'd5);
    chk("t5_nwords", 32'(xq.size()), 32'd2);
    chk("t5_word0", xq[0], 32'h40);

    // A flush cycle suppresses a hit on a resident block.
    bus.imemREN = 1'b1; bus.imemaddr = 32'h44; flush = 1'b1;
    @(negedge CLK);
    chk("flush_hit_masked", 32'(bus.ihit), 32'd0);
    step(1);
    flush = 1'b0; bus.imemREN = 1'b0;
    step(1);

    // Reset in the middle of a fill.
    bus.imemREN = 1'b1; bus.imemaddr = 32'h80;
    step(2);
    RST = 1'b1; bus.imemREN = 1'b0;
    step(1);
    RST = 1'b0;
    @(negedge CLK);
    chk("t6_iREN", 32'(bus.iREN), 32'd0);
    chk("t6_iaddr", bus.iaddr, 32'd0);
    chk("t6_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("t6_miss_cnt", 32'(miss_cnt), 32'd0);
    step(1);
    fetch(32'h40, lat, ld);
    chk("t6_cold_miss", lat, 32'd5);
    chk("t6_miss_cnt1", 32'(miss_cnt), 32'd1);

    // Hit counter saturates at all-ones.
    bus.imemREN = 1'b1; bus.imemaddr = 32'h44;
    step(20);
    bus.imemREN = 1'b0;
    @(negedge CLK);
    chk("sat_hit_cnt", 32'(hit_cnt), 32'd15);
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
